// File: rtl/inst_fetch.sv
// Instruction fetch: owns PC/ROM enable, registers rom_data into IF/ID one edge after pc; optional IF_FETCH_CNT_EN adds fetch_cnt.
// Backpressure: stall_if holds PC and buffers a redirect, stall_id holds IF/ID; flush overrides both.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        pend_valid;
    logic        pend_valid_nxt;
    logic [31:0] pend_addr;
    logic [31:0] pend_addr_nxt;
    logic        id_load;

    assign rom_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rom_ce <= 1'b0;
        end else begin
            state  <= state_nxt;
            rom_ce <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                state_nxt = RUN;
                if (flush) begin
                    pc_nxt         = flush_addr;
                    pend_valid_nxt = 1'b0;
                end else if (stall_if) begin
                    // newest redirect seen during the stall wins
                    if (branch_flag) begin
                        pend_addr_nxt  = branch_addr;
                        pend_valid_nxt = 1'b1;
                    end
                end else if (pend_valid) begin
                    pc_nxt         = branch_flag ? branch_addr : pend_addr;
                    pend_valid_nxt = 1'b0;
                end else if (branch_flag) begin
                    pc_nxt = branch_addr;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_addr  <= 32'h0000_0000;
        end else begin
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_addr  <= pend_addr_nxt;
        end
    end

    assign id_load = !flush && !stall_id && !stall_if && rom_ce;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc    <= 32'h0000_0000;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (stall_id) begin
            id_pc    <= id_pc;
        end else if (id_load) begin
            id_pc    <= pc;
            id_inst  <= rom_data;
            id_valid <= 1'b1;
            id_adel  <= (pc[1:0] != 2'b00);
        end else begin
            // bubble keeps id_pc but must not report a fetch error
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end
    end

`ifdef IF_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'h0000_0000;
        end else if (id_load) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table with constant expectations, then random stimulus against a reference model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] flush_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .branch_flag(branch_flag),
        .branch_addr(branch_addr),
        .flush      (flush),
        .flush_addr (flush_addr),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .id_adel    (id_adel)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000_0000+k; low address bits tag bits [25:24]
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]} + {6'b0, a[1:0], 24'b0};
    endfunction

    assign rom_data = rom_word(rom_addr);

    // reference model state
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_a;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    bit          m_id_v;
    bit          m_id_a;
    logic [31:0] m_cnt;

    task automatic model_step(input bit r, sif, sid, br, input logic [31:0] ba,
                              input bit fl, input logic [31:0] fa);
        logic [31:0] npc;
        if (r) begin
            m_run = 0; m_pc = 32'h0; m_pend = 0; m_pend_a = 32'h0;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_v = 0; m_id_a = 0; m_cnt = 32'h0;
            return;
        end
        npc = m_pc;
        if (m_run) begin
            if (fl) begin npc = fa; m_pend = 0; end
            else if (sif) begin if (br) begin m_pend = 1; m_pend_a = ba; end end
            else if (m_pend) begin npc = br ? ba : m_pend_a; m_pend = 0; end
            else if (br) npc = ba;
            else npc = m_pc + 32'd4;
        end
        if (fl) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_v = 0; m_id_a = 0;
        end else if (!sid) begin
            if (sif || !m_run) begin
                m_id_inst = 32'h0; m_id_v = 0; m_id_a = 0;
            end else begin
                m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_v = 1;
                m_id_a = (m_pc % 4) != 0;
                m_cnt = m_cnt + 32'd1;
            end
        end
        m_pc  = npc;
        m_run = 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, sif, sid, br, input logic [31:0] ba,
                        input bit fl, input logic [31:0] fa);
        @(negedge clk);
        rst = r; stall_if = sif; stall_id = sid; branch_flag = br;
        branch_addr = ba; flush = fl; flush_addr = fa;
        model_step(r, sif, sid, br, ba, fl, fa);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rom_addr"}, rom_addr, m_pc);
        chk({tag, ".rom_ce"}, {31'b0, rom_ce}, {31'b0, m_run});
        chk({tag, ".id_pc"}, id_pc, m_id_pc);
        chk({tag, ".id_inst"}, id_inst, m_id_inst);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_id_v});
        chk({tag, ".id_adel"}, {31'b0, id_adel}, {31'b0, m_id_a});
`ifdef IF_FETCH_CNT_EN
        chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
`endif
    endtask

    typedef struct {
        bit          r, sif, sid, br;
        logic [31:0] ba;
        bit          fl;
        logic [31:0] fa;
        logic [31:0] e_pc;
        bit          e_ce;
        logic [31:0] e_idpc, e_inst;
        bit          e_v, e_a;
    } vec_t;

    function automatic vec_t mk(input bit r, sif, sid, br, input logic [31:0] ba,
                                input bit fl, input logic [31:0] fa,
                                input logic [31:0] e_pc, input bit e_ce,
                                input logic [31:0] e_idpc, e_inst, input bit e_v, e_a);
        vec_t v;
        v.r = r; v.sif = sif; v.sid = sid; v.br = br; v.ba = ba; v.fl = fl; v.fa = fa;
        v.e_pc = e_pc; v.e_ce = e_ce; v.e_idpc = e_idpc; v.e_inst = e_inst; v.e_v = e_v; v.e_a = e_a;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1; stall_if = 0; stall_id = 0; branch_flag = 0; branch_addr = 0;
        flush = 0; flush_addr = 0;
        //                r si sd br ba       fl fa            pc        ce idpc      inst          v a
        tbl.push_back(mk(1, 0, 0, 0, 0,       0, 0,            32'h0,    0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,       0, 0,            32'h0,    0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h0,    1, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h4,    1, 32'h0,    32'h1000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h8,    1, 32'h4,    32'h1000_0001, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h40,  0, 0,            32'h40,   1, 32'h8,    32'h1000_0002, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h44,   1, 32'h40,   32'h1000_0010, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h48,   1, 32'h44,   32'h1000_0011, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,       0, 0,            32'h48,   1, 32'h44,   32'h1000_0011, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h80,  0, 0,            32'h48,   1, 32'h44,   32'h1000_0011, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,       0, 0,            32'h48,   1, 32'h44,   32'h1000_0011, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h80,   1, 32'h48,   32'h1000_0012, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h84,   1, 32'h80,   32'h1000_0020, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,       0, 0,            32'h84,   1, 32'h80,   32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,       1, 32'h380,      32'h380,  1, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h384,  1, 32'h380,  32'h1000_00E0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h500, 0, 0,            32'h384,  1, 32'h380,  32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       1, 32'h600,      32'h600,  1, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h604,  1, 32'h600,  32'h1000_0180, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h42,  0, 0,            32'h42,   1, 32'h604,  32'h1000_0181, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h46,   1, 32'h42,   32'h1200_0010, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h4A,   1, 32'h46,   32'h1200_0011, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0, 32'h0,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h0,    1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h4,    1, 32'h0,    32'h1000_0000, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h100, 0, 0,            32'h4,    1, 32'h0,    32'h1000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h200, 0, 0,            32'h200,  1, 32'h4,    32'h1000_0001, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h204,  1, 32'h200,  32'h1000_0080, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h300, 0, 0,            32'h204,  1, 32'h200,  32'h1000_0080, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,       0, 0,            32'h0,    0, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h0,    1, 32'h0,    32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'h4,    1, 32'h0,    32'h1000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,       0, 0,            32'h8,    1, 32'h0,    32'h1000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,       0, 0,            32'hC,    1, 32'h8,    32'h1000_0002, 1, 0));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].r, tbl[i].sif, tbl[i].sid, tbl[i].br, tbl[i].ba, tbl[i].fl, tbl[i].fa);
            chk({tag, ".rom_addr"}, rom_addr, tbl[i].e_pc);
            chk({tag, ".rom_ce"}, {31'b0, rom_ce}, {31'b0, tbl[i].e_ce});
            chk({tag, ".id_pc"}, id_pc, tbl[i].e_idpc);
            chk({tag, ".id_inst"}, id_inst, tbl[i].e_inst);
            chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, tbl[i].e_v});
            chk({tag, ".id_adel"}, {31'b0, id_adel}, {31'b0, tbl[i].e_a});
        end

`ifdef IF_FETCH_CNT_EN
        // 5 loads, 2 stall cycles, 1 flush, then reset
        step(1, 0, 0, 0, 0, 0, 0);
        chk("cnt.reset", fetch_cnt, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h100);
        chk("cnt.after", fetch_cnt, 32'd5);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("cnt.rst_again", fetch_cnt, 32'h0);
`endif

        for (int k = 0; k < 600; k++) begin
            bit          r, sif, sid, br, fl;
            logic [31:0] ba, fa;
            r   = ($urandom_range(0, 63) == 0);
            sif = ($urandom_range(0, 3) == 0);
            sid = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 5) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            ba  = $urandom & 32'h0000_0FFF;
            fa  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + {30'b0, ba[1:0]} : ($urandom & 32'h0000_3FFC);
            step(r, sif, sid, br, ba, fl, fa);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
